// File: rtl/axis_comb_pkg.sv
// Shared types and ring-index helpers for the AXI-Stream comb decoder.
package axis_comb_pkg;

  localparam int unsigned HIST_DEPTH = 16;
  localparam int unsigned HIST_PTR_W = $clog2(HIST_DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  // (wp - k) mod depth for wp < depth and k <= depth, without a divider
  function automatic int unsigned ring_sub(input int unsigned wp,
                                           input int unsigned k,
                                           input int unsigned depth = HIST_DEPTH);
    int unsigned t;
    t = wp + depth - k;
    return (t >= depth) ? t - depth : t;
  endfunction

endpackage

// File: rtl/comb_history_ring.sv
// History ring of recovered samples: one write port, one asynchronous read
// port addressed as a distance back from the write pointer.
module comb_history_ring
  import axis_comb_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_K  = HIST_DEPTH,
  parameter int unsigned PTR_W  = HIST_PTR_W,
  parameter int unsigned DIST_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              clr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DIST_W-1:0] rd_dist,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [MAX_K];
  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  rp;

  assign rp      = PTR_W'(ring_sub(32'(wp), 32'(rd_dist), MAX_K));
  assign rd_data = mem[rp];

  // Pointer wraps explicitly so MAX_K need not be a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
    end else if (wr_en) begin
      if (clr || (wp == PTR_W'(MAX_K - 1))) wp <= '0;
      else                                  wp <= wp + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= wr_data;
  end

endmodule

// File: rtl/axis_comb_decoder.sv
// AXI-Stream decoder inverting y[n] = x[n] + x[n-k] per packet, with a
// single output register and full backpressure.
module axis_comb_decoder
  import axis_comb_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_K  = HIST_DEPTH,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic [DATA_W-1:0] k,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  pkt_count
);

  localparam int unsigned PTR_W = (MAX_K == HIST_DEPTH) ? HIST_PTR_W :
                                  ((MAX_K > 1) ? $clog2(MAX_K) : 1);
  localparam int unsigned N_W   = $clog2(MAX_K + 1);

  state_t            state_q, state_d;
  logic [N_W-1:0]    k_q;
  logic [N_W-1:0]    n_q;
  logic [N_W-1:0]    k_eff;
  logic              accept;
  logic              k_ok;
  logic              use_hist;
  logic [DATA_W-1:0] hist_rd;
  logic [DATA_W-1:0] dec;

  assign s_ready = !rst && (!m_valid || m_ready);
  assign accept  = s_valid && s_ready;
  assign busy    = (state_q == IN_PKT);

  // First beat of a packet takes k straight from the port, later beats use k_q
  assign k_ok     = (k <= DATA_W'(MAX_K));
  assign k_eff    = (state_q == IDLE) ? (k_ok ? N_W'(k) : '0) : k_q;
  assign use_hist = (k_eff != '0) && (n_q >= k_eff);
  assign dec      = use_hist ? (s_data - hist_rd) : s_data;

  comb_history_ring #(
    .DATA_W (DATA_W),
    .MAX_K  (MAX_K),
    .PTR_W  (PTR_W),
    .DIST_W (N_W)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .clr     (s_last),
    .wr_data (dec),
    .rd_dist (k_eff),
    .rd_data (hist_rd)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept && !s_last) state_d = IN_PKT;
      IN_PKT: if (accept && s_last)  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      n_q       <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= '0;
      cfg_err   <= 1'b0;
      pkt_count <= '0;
    end else begin
      state_q <= state_d;
      if (m_valid && m_ready && m_last) pkt_count <= pkt_count + CNT_W'(1);
      if (accept) begin
        m_valid <= 1'b1;
        m_data  <= dec;
        m_last  <= s_last;
        if (state_q == IDLE) begin
          k_q <= k_eff;
          if (!k_ok) cfg_err <= 1'b1;
        end
        // Beat index only matters up to MAX_K, so it saturates there
        if (s_last)                     n_q <= '0;
        else if (n_q != N_W'(MAX_K))    n_q <= n_q + N_W'(1);
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_comb_decoder.sv
// Directed and randomized bench for axis_comb_decoder against a sample-level
// reference decode / encode model with a beat scoreboard.
module tb_axis_comb_decoder;

  localparam int DATA_W = 8;
  localparam int MAX_K  = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] k = '0;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready = 1'b1;
  logic              busy;
  logic              cfg_err;
  logic [CNT_W-1:0]  pkt_count;

  always #5 clk = ~clk;

  axis_comb_decoder #(
    .DATA_W (DATA_W),
    .MAX_K  (MAX_K),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .k         (k),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .busy      (busy),
    .cfg_err   (cfg_err),
    .pkt_count (pkt_count)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [8:0]  exp_q [$];
  int unsigned exp_pkts = 0;
  logic        exp_busy = 1'b0;
  logic        exp_cfg  = 1'b0;
  logic [7:0]  pkt_y [$];
  logic [7:0]  pkt_x [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference decode: x[n] = y[n] - x[n-k] once n >= k, passthrough for k=0 or k>MAX_K
  function automatic void decode_ref(input int kv);
    logic [7:0] d;
    pkt_x.delete();
    for (int n = 0; n < pkt_y.size(); n++) begin
      d = pkt_y[n];
      if (kv >= 1 && kv <= MAX_K && n >= kv) d = pkt_y[n] - pkt_x[n - kv];
      pkt_x.push_back(d);
    end
  endfunction

  // Random source samples pushed through the encode-side comb
  task automatic make_encoded(input int kv, input int len);
    logic [7:0] v;
    pkt_x.delete();
    pkt_y.delete();
    for (int n = 0; n < len; n++) pkt_x.push_back(8'($urandom));
    for (int n = 0; n < len; n++) begin
      v = pkt_x[n];
      if (kv >= 1 && kv <= MAX_K && n >= kv) v = pkt_x[n] + pkt_x[n - kv];
      pkt_y.push_back(v);
    end
  endtask

  // One clock: drive at edge+1, sample at edge+2, then advance to next edge+1
  task automatic cycle_step(input logic sv, input logic [7:0] sd, input logic sl,
                            input logic [7:0] kv, input logic mr, input logic [7:0] ed,
                            output logic acc);
    logic       stalled;
    logic [7:0] hd;
    logic       hl;
    logic [8:0] e;
    s_valid = sv; s_data = sd; s_last = sl; k = kv; m_ready = mr;
    #1;
    check("s_ready", 32'(s_ready), 32'(!m_valid || mr));
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $error("FAIL spurious_out: observed beat %0h expected none", m_data);
      end else begin
        e = exp_q.pop_front();
        check("m_data", 32'(m_data), 32'(e[7:0]));
        check("m_last", 32'(m_last), 32'(e[8]));
        if (e[8]) exp_pkts++;
      end
    end
    acc     = sv && s_ready;
    stalled = m_valid && !m_ready;
    hd      = m_data;
    hl      = m_last;
    if (acc) begin
      exp_q.push_back({sl, ed});
      exp_busy = !sl;
    end
    @(posedge clk);
    #1;
    if (stalled) begin
      check("hold_valid", 32'(m_valid), 32'(1));
      check("hold_data", 32'(m_data), 32'(hd));
      check("hold_last", 32'(m_last), 32'(hl));
    end
    if (acc) begin
      check("latency_valid", 32'(m_valid), 32'(1));
      check("latency_data", 32'(m_data), 32'(ed));
    end
    check("busy", 32'(busy), 32'(exp_busy));
  endtask

  // mode 0: flow-through, 1: random valid/ready, 2: 3-cycle m_ready stall at beat 3
  task automatic run_packet(input int kv, input int mode);
    int         i = 0;
    int         cyc = 0;
    int         stall = 0;
    bit         stall_done = 1'b0;
    logic       acc, sv, mr;
    logic [7:0] kk;
    if (kv > MAX_K) exp_cfg = 1'b1;
    while (i < pkt_y.size()) begin
      sv = 1'b1;
      mr = 1'b1;
      if (mode == 1) begin
        sv = ($urandom_range(0, 3) != 0);
        mr = ($urandom_range(0, 3) != 0);
      end
      if (mode == 2) begin
        if (i == 3 && !stall_done) begin stall = 3; stall_done = 1'b1; end
        if (stall > 0) begin mr = 1'b0; stall--; end
      end
      kk = (i == 0) ? 8'(kv) : 8'($urandom);
      cycle_step(sv, pkt_y[i], (i == pkt_y.size() - 1), kk, mr, pkt_x[i], acc);
      if (acc) i++;
      cyc++;
      if (cyc > 2000) begin
        n_total++;
        $error("FAIL pkt_timeout: accepted %0d of %0d beats", i, pkt_y.size());
        break;
      end
    end
  endtask

  task automatic drain();
    int   cyc = 0;
    logic acc;
    while (exp_q.size() != 0 && cyc < 100) begin
      cycle_step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, acc);
      cyc++;
    end
    check("drained", 32'(exp_q.size()), 32'(0));
    check("pkt_count", 32'(pkt_count), 32'(exp_pkts[CNT_W-1:0]));
    check("cfg_err", 32'(cfg_err), 32'(exp_cfg));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   kv, len;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 32'(0));
    rst = 1'b0;
    #1;
    check("rst_m_valid", 32'(m_valid), 32'(0));
    check("rst_m_last", 32'(m_last), 32'(0));
    check("rst_m_data", 32'(m_data), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_cfg_err", 32'(cfg_err), 32'(0));
    check("rst_pkt_count", 32'(pkt_count), 32'(0));

    // k=2 basic decode
    pkt_y = '{8'd5, 8'd7, 8'd6, 8'd9};
    pkt_x = '{8'd5, 8'd7, 8'd1, 8'd2};
    run_packet(2, 0);
    drain();
    check("t1_pkt_count", 32'(pkt_count), 32'(1));

    // k=1 with mod-256 wrap, then k=3 with no history carried over
    pkt_y = '{8'd3, 8'd1};
    pkt_x = '{8'd3, 8'd254};
    run_packet(1, 0);
    pkt_y = '{8'd10, 8'd20, 8'd30, 8'd45};
    pkt_x = '{8'd10, 8'd20, 8'd30, 8'd35};
    run_packet(3, 0);
    drain();

    // Mid-packet stall on the output
    pkt_y = '{8'd11, 8'd22, 8'd40, 8'd60, 8'd90, 8'd7};
    decode_ref(2);
    run_packet(2, 2);
    drain();

    // Out-of-range k passes through and latches cfg_err
    pkt_y = '{8'd4, 8'd4, 8'd4};
    pkt_x = '{8'd4, 8'd4, 8'd4};
    run_packet(20, 0);
    drain();
    make_encoded(2, 5);
    run_packet(2, 0);
    drain();

    // k=MAX_K across ring wrap
    pkt_y.delete();
    for (int n = 0; n < 40; n++) pkt_y.push_back(8'(n));
    decode_ref(16);
    run_packet(16, 0);
    drain();

    // Reset mid-packet
    pkt_y = '{8'd1, 8'd2, 8'd3, 8'd4};
    decode_ref(2);
    cycle_step(1'b1, pkt_y[0], 1'b0, 8'd2, 1'b1, pkt_x[0], acc);
    cycle_step(1'b1, pkt_y[1], 1'b0, 8'd2, 1'b1, pkt_x[1], acc);
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_pkts = 0;
    exp_busy = 1'b0;
    exp_cfg  = 1'b0;
    #1;
    check("mid_rst_m_valid", 32'(m_valid), 32'(0));
    check("mid_rst_pkt_count", 32'(pkt_count), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_cfg_err", 32'(cfg_err), 32'(0));
    pkt_y = '{8'd9, 8'd8, 8'd7, 8'd6};
    pkt_x = '{8'd9, 8'd8, 8'd254, 8'd254};
    run_packet(2, 0);
    drain();

    // Randomized packets with random flow control
    for (int p = 0; p < 25; p++) begin
      kv  = $urandom_range(0, 20);
      len = $urandom_range(1, 40);
      make_encoded(kv, len);
      if (kv > MAX_K) pkt_x = pkt_y;
      run_packet(kv, 1);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axis_comb_decoder.md
Name: axis_comb_decoder

Overview:
- AXI-Stream packet decoder; inverts the per-packet comb accumulation y[n] = x[n] + x[n-k] (mod 2^DATA_W) applied on the encode side.
- Recovers x[n] = y[n] - x[n-k] for n >= k, and x[n] = y[n] for n < k.
- Sits downstream of the packet encoder on the receive path; keeps a ring history of recovered samples and provides full AXI-Stream backpressure.

Parameters:
- DATA_W, 8, beat width in bits.
- MAX_K, 16, maximum supported comb delay; history depth.
- CNT_W, 16, width of the packet counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_data  in  DATA_W  encoded beat y[n].
- s_valid  in  1  slave valid.
- s_last  in  1  final beat of the packet.
- s_ready  out  1  slave ready.
- k  in  DATA_W  comb delay; sampled on the first beat of each packet.
- m_data  out  DATA_W  decoded beat x[n].
- m_valid  out  1  master valid.
- m_last  out  1  final beat of the packet.
- m_ready  in  1  master ready.
- busy  out  1  high while a packet is in progress (state IN_PKT).
- cfg_err  out  1  sticky; set when a packet starts with k > MAX_K.
- pkt_count  out  CNT_W  count of packets fully emitted (m_last handshakes); wraps.

Behaviour:
- Reset values: s_ready=0 while rst is high; m_valid=0, m_last=0, m_data=0, busy=0, cfg_err=0, pkt_count=0. History write pointer, beat counter and k_q are cleared; state=IDLE.
- Handshake:
  - s_ready = !rst && (!m_valid || m_ready). This is a single output register, so there is no bubble under continuous flow.
  - A beat is accepted when s_valid && s_ready. The decoded beat appears on m_* the next cycle: 1-cycle latency.
  - m_* holds stable while m_valid && !m_ready. m_valid drops after the m_ready handshake if no new beat was accepted in the same cycle.
- FSM:
  - IDLE: on an accepted beat, latch k_eff. k_eff = k if k <= MAX_K; otherwise k_eff = 0, cfg_err is set, and the packet passes through unchanged. Go to IN_PKT unless s_last is set, in which case stay in IDLE (single-beat packet).
  - IN_PKT: on an accepted beat with s_last, go to IDLE.
  - The first beat always uses the combinational k value, not the stale k_q.
- Decode, per accepted beat:
  - n is the beat index within the packet. It saturates at MAX_K; it is not needed beyond that.
  - If k_eff == 0 or n < k_eff: x = y. Otherwise x = y - hist[(wp - k_eff) mod MAX_K], with the subtraction mod 2^DATA_W.
  - Write x to hist[wp], then wp = (wp + 1) mod MAX_K.
  - The ring wraps explicitly with no power-of-2 assumption.
- Packet boundary: on an accepted s_last beat, wp and n are reset to 0 so the next packet sees no history. Stale history contents are never read, because of the n < k_eff guard.
- Simultaneous events: an m_ready handshake and a new accept in the same cycle replace m_* with no gap. pkt_count increments on m_valid && m_ready && m_last.
- Reset mid-packet drops the in-flight beat and partial packet. The first beat after reset is treated as a packet start.
- cfg_err clears only on rst.

Decomposition:
- Package axis_comb_pkg: state enum {IDLE, IN_PKT}; localparam for the ring pointer width clog2(MAX_K); a helper function ring_sub(wp, k) returning (wp - k) mod MAX_K.
- Sub-module comb_history_ring: MAX_K x DATA_W register array with one write port, one asynchronous read port, and the pointer wrap logic.
- The top module holds the FSM, the output register and the counters.

Test Plan:
- k=2; send 5,7,6,9 with last on 9, m_ready=1 -> m_data 5,7,1,2; m_last only on the 4th beat; each output 1 cycle after its input; pkt_count=1.
- k=1; send 3,1 -> outputs 3,254 (mod-256 wrap); then k=3, send 10,20,30,45 -> 10,20,30,35, showing no history leak across packets.
- k=2, 6 beats, m_ready low for 3 cycles mid-packet -> s_ready=0 and m_* held stable during the stall; output sequence identical to the no-stall run; no beat lost or duplicated.
- k=20 (> MAX_K=16); send 4,4,4 -> outputs 4,4,4 passthrough; cfg_err=1 and stays 1 across the next valid packet; cleared by rst.
- MAX_K=16, k=16; 40-beat packet with y[n]=n -> x matches the reference model through ring wrap, with the first subtraction occurring at n=16.
- rst asserted for 1 cycle mid-packet (k=2, after 2 beats) -> m_valid=0 and pkt_count=0 after reset; the next packet decodes with fresh history.
